read_buf: RTL and testbench

- Read-side counterpart of the DMA-to-buffer write path.
- Accepts data (DAT) and weight (WT) read requests addressed in the flat buffer space, splits each address into bank index and in-bank offset, and drives the banked logic memory read port.
- Tracks each request through the BRAM read latency, then returns bank data with a valid pulse to the requesting side.
- Sits between the CNN buffer banks and the convolution feature and weight fetch engines.

---
 rtl/read_buf_pkg.sv | 66 ++++++
 rtl/read_buf_lat_pipe.sv | 32 +++
 rtl/read_buf.sv | 117 +++++++++++
 tb/tb_read_buf.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_buf_pkg.sv
// Shared widths, the response tag layout and bank-decode helpers for read_buf.
// The `ifndef block mirrors CNN_defines.vh so the slice also builds standalone.
`ifndef log2BUF_DEP
`define log2BUF_DEP 12
`endif
`ifndef log2BRAM_DEPTH
`define log2BRAM_DEPTH 9
`endif
`ifndef BRAM_NUM
`define BRAM_NUM 4
`endif
`ifndef log2BRAM_NUM
`define log2BRAM_NUM 2
`endif
`ifndef base_Tin
`define base_Tin 2
`endif
`ifndef MAX_DW
`define MAX_DW 16
`endif
`ifndef MAX_DAT_DW
`define MAX_DAT_DW 16
`endif
`ifndef MAX_WT_DW
`define MAX_WT_DW 8
`endif
`ifndef RD_TAG_W
`define RD_TAG_W (2 + `log2BRAM_NUM)
`endif

package read_buf_pkg;
   localparam int BUF_AW   = `log2BUF_DEP;
   localparam int BRAM_AW  = `log2BRAM_DEPTH;
   localparam int BRAM_NUM = `BRAM_NUM;
   localparam int BANK_W   = `log2BRAM_NUM;
   localparam int BIDX_W   = BUF_AW - BRAM_AW;
   localparam int SLICE_W  = `base_Tin * `MAX_DW;
   localparam int MEM_W    = BRAM_NUM * SLICE_W;
   localparam int DAT_W    = `base_Tin * `MAX_DAT_DW;
   localparam int WT_W     = `base_Tin * `MAX_WT_DW;
   localparam int TAG_W    = `RD_TAG_W;
`ifdef READ_BUF_PARALLEL_EN
   localparam int RDADDR_W = BRAM_NUM * BRAM_AW;
`else
   localparam int RDADDR_W = BRAM_AW;
`endif

   typedef struct packed {
      logic              is_wt;
      logic              oob;
      logic [BANK_W-1:0] bank;
   } rd_tag_t;

   function automatic logic is_oob(input logic [BIDX_W-1:0] idx);
      return {1'b0, idx} >= (BIDX_W+1)'(BRAM_NUM);
   endfunction

   // Out-of-range indices match no bank, so they decode to all zeros.
   function automatic logic [BRAM_NUM-1:0] bank_onehot(input logic [BIDX_W-1:0] idx);
      logic [BRAM_NUM-1:0] oh;
      oh = '0;
      for (int i = 0; i < BRAM_NUM; i++)
         if ({1'b0, idx} == (BIDX_W+1)'(i)) oh[i] = 1'b1;
      return oh;
   endfunction
endpackage

// File: rtl/read_buf_lat_pipe.sv
// Valid/tag delay line matching the BRAM read latency; valid bits clear synchronously.
module read_buf_lat_pipe #(
   parameter int RD_LAT = 2,
   parameter int WIDTH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_tag,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_tag
);
   logic [RD_LAT-1:0] vld_q;
   logic [WIDTH-1:0]  tag_q [RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= in_vld;
         for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
   end

   assign out_vld = vld_q[RD_LAT-1];
   assign out_tag = tag_q[RD_LAT-1];
endmodule

// File: rtl/read_buf.sv
// Banked buffer read port shared by the DAT and WT fetch engines (DAT has priority).
// Define READ_BUF_PARALLEL_EN to let DAT and WT issue together when their banks differ.
module read_buf
   import read_buf_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dat_rd_req,
   input  logic [BUF_AW-1:0]   dat_rd_addr,
   output logic                dat_rd_rdy,
   input  logic                wt_rd_req,
   input  logic [BUF_AW-1:0]   wt_rd_addr,
   output logic                wt_rd_rdy,
   output logic [BRAM_NUM-1:0] logic_mem_rd_en,
   output logic [RDADDR_W-1:0] logic_mem_rd_addr,
   input  logic [MEM_W-1:0]    logic_mem_rd_dat,
   output logic                dat_rd_vld,
   output logic [DAT_W-1:0]    dat_rd_data,
   output logic                wt_rd_vld,
   output logic [WT_W-1:0]     wt_rd_data
);
   logic              dat_pipe_vld, wt_pipe_vld;
   logic [TAG_W-1:0]  dat_pipe_tag, wt_pipe_tag;
   rd_tag_t           dat_lat_tag, wt_lat_tag;
   logic              dat_lat_vld, wt_lat_vld;
   logic [DAT_W-1:0]  dat_cap;
   logic [WT_W-1:0]   wt_cap;

`ifdef READ_BUF_PARALLEL_EN
   logic [BIDX_W-1:0]   dat_idx_p0, wt_idx_p0;
   logic [BRAM_NUM-1:0] dat_oh_p0, wt_oh_p0;
   rd_tag_t             dat_tag_p0, wt_tag_p0;

   // Stage p0: independent decode per lane; WT only yields on a bank clash.
   always_comb begin
      dat_idx_p0 = dat_rd_addr[BUF_AW-1:BRAM_AW];
      wt_idx_p0  = wt_rd_addr[BUF_AW-1:BRAM_AW];
      dat_rd_rdy = dat_rd_req & ~rst;
      wt_rd_rdy  = wt_rd_req & ~(dat_rd_req & (dat_idx_p0 == wt_idx_p0)) & ~rst;
      dat_oh_p0  = dat_rd_rdy ? bank_onehot(dat_idx_p0) : '0;
      wt_oh_p0   = wt_rd_rdy ? bank_onehot(wt_idx_p0) : '0;
      logic_mem_rd_en   = dat_oh_p0 | wt_oh_p0;
      logic_mem_rd_addr = '0;
      for (int i = 0; i < BRAM_NUM; i++) begin
         if (dat_oh_p0[i])
            logic_mem_rd_addr[i*BRAM_AW +: BRAM_AW] = dat_rd_addr[BRAM_AW-1:0];
         else if (wt_oh_p0[i])
            logic_mem_rd_addr[i*BRAM_AW +: BRAM_AW] = wt_rd_addr[BRAM_AW-1:0];
      end
      dat_tag_p0 = '{is_wt: 1'b0, oob: is_oob(dat_idx_p0), bank: dat_idx_p0[BANK_W-1:0]};
      wt_tag_p0  = '{is_wt: 1'b1, oob: is_oob(wt_idx_p0), bank: wt_idx_p0[BANK_W-1:0]};
   end

   read_buf_lat_pipe #(.RD_LAT(RD_LAT), .WIDTH(TAG_W)) u_dat_pipe (
      .clk(clk), .rst(rst), .in_vld(dat_rd_rdy), .in_tag(dat_tag_p0),
      .out_vld(dat_pipe_vld), .out_tag(dat_pipe_tag));
   read_buf_lat_pipe #(.RD_LAT(RD_LAT), .WIDTH(TAG_W)) u_wt_pipe (
      .clk(clk), .rst(rst), .in_vld(wt_rd_rdy), .in_tag(wt_tag_p0),
      .out_vld(wt_pipe_vld), .out_tag(wt_pipe_tag));
`else
   logic              acc_p0;
   logic [BUF_AW-1:0] addr_p0;
   logic [BIDX_W-1:0] idx_p0;
   rd_tag_t           tag_p0;

   // Stage p0: single shared port, fixed DAT priority.
   always_comb begin
      dat_rd_rdy = dat_rd_req & ~rst;
      wt_rd_rdy  = wt_rd_req & ~dat_rd_req & ~rst;
      acc_p0     = dat_rd_rdy | wt_rd_rdy;
      addr_p0    = wt_rd_rdy ? wt_rd_addr : dat_rd_addr;
      idx_p0     = addr_p0[BUF_AW-1:BRAM_AW];
      logic_mem_rd_en   = acc_p0 ? bank_onehot(idx_p0) : '0;
      logic_mem_rd_addr = acc_p0 ? addr_p0[BRAM_AW-1:0] : '0;
      tag_p0 = '{is_wt: wt_rd_rdy, oob: is_oob(idx_p0), bank: idx_p0[BANK_W-1:0]};
   end

   read_buf_lat_pipe #(.RD_LAT(RD_LAT), .WIDTH(TAG_W)) u_pipe (
      .clk(clk), .rst(rst), .in_vld(acc_p0), .in_tag(tag_p0),
      .out_vld(dat_pipe_vld), .out_tag(dat_pipe_tag));
   assign wt_pipe_vld = dat_pipe_vld;
   assign wt_pipe_tag = dat_pipe_tag;
`endif

   // Stage p1: BRAM data is valid alongside the oldest tag; pick the slice.
   always_comb begin
      dat_lat_tag = rd_tag_t'(dat_pipe_tag);
      wt_lat_tag  = rd_tag_t'(wt_pipe_tag);
      dat_lat_vld = dat_pipe_vld & ~dat_lat_tag.is_wt;
      wt_lat_vld  = wt_pipe_vld & wt_lat_tag.is_wt;
      dat_cap = '0;
      wt_cap  = '0;
      for (int i = 0; i < BRAM_NUM; i++) begin
         if (!dat_lat_tag.oob && dat_lat_tag.bank == BANK_W'(i))
            dat_cap = logic_mem_rd_dat[i*SLICE_W +: DAT_W];
         if (!wt_lat_tag.oob && wt_lat_tag.bank == BANK_W'(i))
            wt_cap = logic_mem_rd_dat[i*SLICE_W +: WT_W];
      end
   end

   // Stage p2: registered return; data holds between valid pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         dat_rd_vld  <= 1'b0;
         wt_rd_vld   <= 1'b0;
         dat_rd_data <= '0;
         wt_rd_data  <= '0;
      end else begin
         dat_rd_vld <= dat_lat_vld;
         wt_rd_vld  <= wt_lat_vld;
         if (dat_lat_vld) dat_rd_data <= dat_cap;
         if (wt_lat_vld)  wt_rd_data  <= wt_cap;
      end
   end
endmodule

// File: tb/tb_read_buf.sv
// Scoreboard bench for read_buf with a banked BRAM model returning {bank, offset} patterns.
module tb_read_buf;
   import read_buf_pkg::*;
   localparam int RD_LAT = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic                dat_rd_req, wt_rd_req;
   logic [BUF_AW-1:0]   dat_rd_addr, wt_rd_addr;
   logic                dat_rd_rdy, wt_rd_rdy;
   logic [BRAM_NUM-1:0] logic_mem_rd_en;
   logic [RDADDR_W-1:0] logic_mem_rd_addr;
   logic [MEM_W-1:0]    logic_mem_rd_dat;
   logic                dat_rd_vld, wt_rd_vld;
   logic [DAT_W-1:0]    dat_rd_data;
   logic [WT_W-1:0]     wt_rd_data;

   read_buf #(.RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .dat_rd_req(dat_rd_req), .dat_rd_addr(dat_rd_addr), .dat_rd_rdy(dat_rd_rdy),
      .wt_rd_req(wt_rd_req), .wt_rd_addr(wt_rd_addr), .wt_rd_rdy(wt_rd_rdy),
      .logic_mem_rd_en(logic_mem_rd_en), .logic_mem_rd_addr(logic_mem_rd_addr),
      .logic_mem_rd_dat(logic_mem_rd_dat),
      .dat_rd_vld(dat_rd_vld), .dat_rd_data(dat_rd_data),
      .wt_rd_vld(wt_rd_vld), .wt_rd_data(wt_rd_data));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int wt_vld_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [SLICE_W-1:0] pat(input int b, input logic [BRAM_AW-1:0] off);
      logic [31:0] v;
      v = {8'(8'hA0 + b), 7'b0, off, 8'(b * 17)};
      return SLICE_W'(v);
   endfunction

   function automatic int bidx(input logic [BUF_AW-1:0] a);
      return int'(a >> BRAM_AW);
   endfunction

   function automatic logic [BRAM_NUM-1:0] oh(input logic [BUF_AW-1:0] a);
      logic [BRAM_NUM-1:0] r;
      r = '0;
      if (bidx(a) < BRAM_NUM) r[bidx(a)] = 1'b1;
      return r;
   endfunction

   function automatic logic [63:0] exp_data(input logic [BUF_AW-1:0] a);
      logic [BRAM_AW-1:0] off;
      off = a[BRAM_AW-1:0];
      if (bidx(a) >= BRAM_NUM) return 64'd0;
      return 64'(pat(bidx(a), off));
   endfunction

   // Banked BRAM model: RD_LAT registered stages, output holds between reads.
   logic [SLICE_W-1:0] mem_q [BRAM_NUM][RD_LAT];
   initial
      for (int b = 0; b < BRAM_NUM; b++)
         for (int s = 0; s < RD_LAT; s++) mem_q[b][s] = '0;

   always @(posedge clk) begin
      for (int b = 0; b < BRAM_NUM; b++) begin
`ifdef READ_BUF_PARALLEL_EN
         if (logic_mem_rd_en[b]) mem_q[b][0] <= pat(b, logic_mem_rd_addr[b*BRAM_AW +: BRAM_AW]);
`else
         if (logic_mem_rd_en[b]) mem_q[b][0] <= pat(b, logic_mem_rd_addr);
`endif
         for (int s = 1; s < RD_LAT; s++) mem_q[b][s] <= mem_q[b][s-1];
      end
   end

   always_comb begin
      logic_mem_rd_dat = '0;
      for (int b = 0; b < BRAM_NUM; b++)
         logic_mem_rd_dat[b*SLICE_W +: SLICE_W] = mem_q[b][RD_LAT-1];
   end

   typedef struct {
      logic [63:0] data;
      int          cyc;
   } exp_t;
   exp_t dat_q[$];
   exp_t wt_q[$];

   // Monitor: checks issue-side behaviour, pushes expectations, pops on vld.
   always @(negedge clk) begin
      logic                same, w_rdy_exp, d_acc, w_acc;
      logic [BRAM_NUM-1:0] en_exp;
      logic [RDADDR_W-1:0] addr_exp;
      exp_t                e;
      if (!rst) begin
`ifdef READ_BUF_PARALLEL_EN
         same = (bidx(dat_rd_addr) == bidx(wt_rd_addr));
`else
         same = 1'b1;
`endif
         w_rdy_exp = wt_rd_req & ~(dat_rd_req & same);
         chk("dat_rdy", 64'(dat_rd_rdy), 64'(dat_rd_req));
         chk("wt_rdy", 64'(wt_rd_rdy), 64'(w_rdy_exp));
         d_acc = dat_rd_req & dat_rd_rdy;
         w_acc = wt_rd_req & wt_rd_rdy;
         en_exp = '0;
         addr_exp = '0;
`ifdef READ_BUF_PARALLEL_EN
         for (int b = BRAM_NUM - 1; b >= 0; b--) begin
            if (w_acc && oh(wt_rd_addr)[b]) begin
               en_exp[b] = 1'b1;
               addr_exp[b*BRAM_AW +: BRAM_AW] = wt_rd_addr[BRAM_AW-1:0];
            end
            if (d_acc && oh(dat_rd_addr)[b]) begin
               en_exp[b] = 1'b1;
               addr_exp[b*BRAM_AW +: BRAM_AW] = dat_rd_addr[BRAM_AW-1:0];
            end
         end
`else
         if (d_acc) begin
            en_exp = oh(dat_rd_addr);
            addr_exp = dat_rd_addr[BRAM_AW-1:0];
         end else if (w_acc) begin
            en_exp = oh(wt_rd_addr);
            addr_exp = wt_rd_addr[BRAM_AW-1:0];
         end
`endif
         chk("rd_en", 64'(logic_mem_rd_en), 64'(en_exp));
         chk("rd_addr", 64'(logic_mem_rd_addr), 64'(addr_exp));
         if (d_acc) dat_q.push_back('{exp_data(dat_rd_addr), cyc + RD_LAT + 1});
         if (w_acc) wt_q.push_back('{exp_data(wt_rd_addr) & 64'((1 << WT_W) - 1), cyc + RD_LAT + 1});
         if (dat_rd_vld) begin
            if (dat_q.size() == 0) chk("dat_extra_vld", 64'd1, 64'd0);
            else begin
               e = dat_q.pop_front();
               chk("dat_data", 64'(dat_rd_data), e.data);
               chk("dat_latency", 64'(cyc), 64'(e.cyc));
            end
         end
         if (wt_rd_vld) begin
            wt_vld_cnt++;
            if (wt_q.size() == 0) chk("wt_extra_vld", 64'd1, 64'd0);
            else begin
               e = wt_q.pop_front();
               chk("wt_data", 64'(wt_rd_data), e.data);
               chk("wt_latency", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   // Holds each request until accepted; both sides may be active at once.
   task automatic issue(input logic dq, input logic [BUF_AW-1:0] da,
                        input logic wq, input logic [BUF_AW-1:0] wa);
      int  n;
      logic d_acc, w_acc;
      n = 0;
      dat_rd_req = dq; dat_rd_addr = da;
      wt_rd_req  = wq; wt_rd_addr  = wa;
      while ((dat_rd_req || wt_rd_req) && n < 20) begin
         @(negedge clk);
         d_acc = dat_rd_req & dat_rd_rdy;
         w_acc = wt_rd_req & wt_rd_rdy;
         @(posedge clk); #1;
         if (d_acc) dat_rd_req = 1'b0;
         if (w_acc) wt_rd_req = 1'b0;
         n++;
      end
      if (n >= 20) begin
         chk("issue_timeout", 64'd1, 64'd0);
         dat_rd_req = 1'b0;
         wt_rd_req = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int wt_base;
      rst = 1'b1;
      dat_rd_req = 1'b0; wt_rd_req = 1'b0;
      dat_rd_addr = '0;  wt_rd_addr = '0;
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_dat_vld", 64'(dat_rd_vld), 64'd0);
      chk("rst_wt_vld", 64'(wt_rd_vld), 64'd0);
      chk("rst_dat_data", 64'(dat_rd_data), 64'd0);
      chk("rst_wt_data", 64'(wt_rd_data), 64'd0);

      // Single DAT read in cycle 10, explicit issue-side check.
      while (cyc != 10) begin @(posedge clk); #1; end
      dat_rd_req = 1'b1; dat_rd_addr = 12'h205;
      @(negedge clk);
      chk("t1_rd_en", 64'(logic_mem_rd_en), 64'b0010);
`ifdef READ_BUF_PARALLEL_EN
      chk("t1_rd_addr", 64'(logic_mem_rd_addr[BRAM_AW +: BRAM_AW]), 64'h005);
`else
      chk("t1_rd_addr", 64'(logic_mem_rd_addr), 64'h005);
`endif
      @(posedge clk); #1;
      dat_rd_req = 1'b0;
      idle(6);

      // Simultaneous DAT/WT requests.
      issue(1'b1, 12'h010, 1'b1, 12'h410);
      idle(6);

      // 16 back-to-back WT reads.
      wt_base = wt_vld_cnt;
      for (int i = 0; i < 16; i++) issue(1'b0, '0, 1'b1, BUF_AW'(i));
      idle(6);
      chk("t3_wt_count", 64'(wt_vld_cnt - wt_base), 64'd16);

      // Out-of-range bank.
      issue(1'b1, 12'hA00, 1'b0, '0);
      idle(6);

      // Reset with two reads in flight.
      issue(1'b1, 12'h001, 1'b0, '0);
      issue(1'b0, '0, 1'b1, 12'h402);
      rst = 1'b1;
      dat_q.delete();
      wt_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_dat_vld", 64'(dat_rd_vld), 64'd0);
      chk("t5_wt_vld", 64'(wt_rd_vld), 64'd0);
      chk("t5_dat_data", 64'(dat_rd_data), 64'd0);
      chk("t5_wt_data", 64'(wt_rd_data), 64'd0);
      idle(8);

`ifdef READ_BUF_PARALLEL_EN
      issue(1'b1, 12'h000, 1'b1, 12'h400);
      idle(6);
      issue(1'b1, 12'h003, 1'b1, 12'h00F);
      idle(6);
`endif

      // Mixed traffic including cross/same-bank and out-of-range addresses.
      for (int i = 0; i < 24; i++)
         issue(1'($urandom_range(0, 1)), BUF_AW'($urandom_range(0, 12'hBFF)),
               1'($urandom_range(0, 1)), BUF_AW'($urandom_range(0, 12'hBFF)));
      idle(10);
      chk("dat_q_drained", 64'(dat_q.size()), 64'd0);
      chk("wt_q_drained", 64'(wt_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
